io_handshake_port: RTL and testbench
====================================

IO_HANDSHAKE_PORT -- requirements
Module: io_handshake_port

Interface
REQ-001 Parameter d_width, default 8, byte width of both data paths.
REQ-002 Parameter depth, default 4, number of entries in the receive buffer (power of two, at least 2).
REQ-003 Ports:
- g_clk  input  1  sole clock, rising edge.
- g_clr  input  1  asynchronous, active-high reset.
- proc_data  input  d_width  byte driven by the processor output register.
- proc_req  input  1  processor "output byte valid" strobe (4-phase request).
- dev_ack  output  1  acknowledge to proc_req.
- dev_data  output  d_width  byte presented to the processor input register.
- dev_req  output  1  "input byte valid" request to the processor.
- proc_ack  input  1  processor acknowledge to dev_req.
- rx_data  output  d_width  head of the receive buffer, for the local consumer.
- rx_valid  output  1  receive buffer not empty.
- rx_ready  input  1  consumer pops the head when rx_valid && rx_ready.
- rx_count  output  log2(depth)+1  receive buffer occupancy.
- tx_data  input  d_width  byte from the local producer.
- tx_valid  input  1  producer offers tx_data.
- tx_ready  output  1  transmitter can accept a byte.
REQ-004 All inputs SHALL be synchronous to g_clk; no synchronizers are instantiated.

Function
REQ-005 The receive FSM SHALL have states R_IDLE and R_ACK.
REQ-006 In R_IDLE with proc_req=1 and registered full=0: write proc_data into the buffer, go to R_ACK; dev_ack=1 from the next cycle.
REQ-007 In R_IDLE with proc_req=1 and full=1: stay in R_IDLE, dev_ack=0, write nothing (stall until space).
REQ-008 In R_ACK: hold dev_ack=1 until proc_req=0, then return to R_IDLE with dev_ack=0 the following cycle; exactly one write per request.
REQ-009 dev_ack SHALL be a registered output equal to (state==R_ACK).
REQ-010 The buffer SHALL be a circular FIFO; write and read pointers wrap modulo depth.
REQ-011 Pop SHALL occur on rx_valid && rx_ready; a pop when empty is ignored.
REQ-012 A simultaneous push and pop SHALL leave rx_count unchanged.
REQ-013 When full, a push is refused even if a pop occurs the same cycle; the push is accepted on the next cycle.
REQ-014 rx_data SHALL show the head entry combinationally from storage; contents are undefined when rx_valid=0.
REQ-015 The transmit FSM SHALL have states T_IDLE, T_REQ and T_REL.
REQ-016 tx_ready=1 only in T_IDLE.
REQ-017 In T_IDLE with tx_valid=1: capture tx_data into the hold register, go to T_REQ.
REQ-018 In T_REQ: dev_req=1 and dev_data=hold; stay until proc_ack=1, then go to T_REL.
REQ-019 In T_REL: dev_req=0 and dev_data is held; stay until proc_ack=0, then go to T_IDLE.
REQ-020 One transmit transfer SHALL take at least 3 cycles; there is no back-to-back overlap.
REQ-021 The receive and transmit paths SHALL operate independently and concurrently.

Reset
REQ-022 On g_clr=1, regardless of the clock:
- both FSMs go to idle;
- dev_ack=0, dev_req=0;
- dev_data=0, hold register=0;
- pointers=0, rx_count=0, rx_valid=0;
- tx_ready=1 after release.
REQ-023 Reset mid-handshake SHALL abandon the transfer and drop dev_ack/dev_req immediately; buffer contents are discarded; storage array need not be cleared.

Structure
REQ-024 State encodings (R_IDLE/R_ACK, T_IDLE/T_REQ/T_REL) and default d_width/depth constants SHALL reside in the shared processor package.
REQ-025 The FIFO SHALL be a separate sub-module, byte_fifo (parameters d_width, depth), instantiated once; both FSMs stay in io_handshake_port.

Verification
REQ-026 Single receive: proc_data=8'hA5, proc_req high until ack -> dev_ack rises 1 cycle later, falls 1 cycle after proc_req falls; rx_valid=1, rx_data=8'hA5, rx_count=1.
REQ-027 Full stall: depth=4, rx_ready=0, five requests 01..05 -> four acked, fifth sees dev_ack=0; pop one -> 05 acked next cycle; pops yield 01..05 in order.
REQ-028 Wrap and simultaneous: push/pop 10 bytes with rx_ready=1 and push/pop in the same cycle -> order preserved across pointer wrap; rx_count never exceeds 4 and is unchanged on concurrent cycles.
REQ-029 Transmit: tx_data=8'h3C, tx_valid pulse -> tx_ready=0, dev_req=1 with dev_data=8'h3C; proc_ack after 2 cycles -> dev_req=0; proc_ack low -> tx_ready=1.
REQ-030 Reset mid-operation: g_clr asserted in R_ACK and T_REQ between clock edges -> dev_ack, dev_req and rx_count go 0 immediately; after release a new A5 receive completes normally.

Source files
------------

// File: rtl/io_handshake_port_pkg.sv
// Shared processor-port definitions: FSM state encodings and default path widths.
// Pure declarations; no logic, no latency, no flow control.
package io_handshake_port_pkg;

    localparam int D_WIDTH_DEF = 8;
    localparam int DEPTH_DEF   = 4;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_REQ  = 2'd1,
        T_REL  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/io_handshake_port_byte_fifo.sv
// Circular byte FIFO with combinational head; one-cycle write-to-visible latency.
// Backpressure: full is registered, so a push while full is refused even if a pop lands the same cycle.
module byte_fifo
    import io_handshake_port_pkg::*;
#(
    parameter int d_width = D_WIDTH_DEF,
    parameter int depth   = DEPTH_DEF,
    localparam int aw     = $clog2(depth)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [d_width-1:0] push_data,
    output logic               full,
    input  logic               pop,
    output logic [d_width-1:0] head,
    output logic               valid,
    output logic [aw:0]        count
);

    localparam logic [aw:0] FULL_CNT = (aw+1)'(depth);

    logic [d_width-1:0] mem [depth];
    logic [aw-1:0]      wr_ptr;
    logic [aw-1:0]      rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == FULL_CNT);
    assign valid   = (count != '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && valid;
    assign head    = mem[rd_ptr];

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/io_handshake_port.sv
// Processor I/O port: 4-phase receive into a byte FIFO, 4-phase transmit from a hold register.
// dev_ack/dev_req are registered (1 cycle); receive stalls while the FIFO is full, tx_ready only when idle.
module io_handshake_port
    import io_handshake_port_pkg::*;
#(
    parameter int d_width = D_WIDTH_DEF,
    parameter int depth   = DEPTH_DEF
) (
    input  logic                   g_clk,
    input  logic                   g_clr,
    input  logic [d_width-1:0]     proc_data,
    input  logic                   proc_req,
    output logic                   dev_ack,
    output logic [d_width-1:0]     dev_data,
    output logic                   dev_req,
    input  logic                   proc_ack,
    output logic [d_width-1:0]     rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [$clog2(depth):0] rx_count,
    input  logic [d_width-1:0]     tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready
);

    rx_state_t          r_state, r_next;
    tx_state_t          t_state, t_next;
    logic               fifo_full;
    logic               rx_push;
    logic               tx_capture;
    logic [d_width-1:0] hold;

    byte_fifo #(
        .d_width (d_width),
        .depth   (depth)
    ) u_rx_fifo (
        .clk       (g_clk),
        .rst       (g_clr),
        .push      (rx_push),
        .push_data (proc_data),
        .full      (fifo_full),
        .pop       (rx_ready),
        .head      (rx_data),
        .valid     (rx_valid),
        .count     (rx_count)
    );

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // The single write happens on the IDLE->ACK transition, so a held request never double-writes.
    always_comb begin
        r_next  = r_state;
        rx_push = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (proc_req && !fifo_full) begin
                    rx_push = 1'b1;
                    r_next  = R_ACK;
                end
            end
            R_ACK: begin
                if (!proc_req) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign dev_ack = (r_state == R_ACK);

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            t_state <= T_IDLE;
            hold    <= '0;
        end else begin
            t_state <= t_next;
            if (tx_capture) hold <= tx_data;
        end
    end

    always_comb begin
        t_next     = t_state;
        tx_capture = 1'b0;
        case (t_state)
            T_IDLE: begin
                if (tx_valid) begin
                    tx_capture = 1'b1;
                    t_next     = T_REQ;
                end
            end
            T_REQ: begin
                if (proc_ack) t_next = T_REL;
            end
            T_REL: begin
                if (!proc_ack) t_next = T_IDLE;
            end
            default: t_next = T_IDLE;
        endcase
    end

    assign dev_req  = (t_state == T_REQ);
    assign tx_ready = (t_state == T_IDLE);
    assign dev_data = hold;

endmodule

// File: tb/tb_io_handshake_port.sv
// Scoreboarded bench for io_handshake_port: directed receive, stall, wrap, transmit and reset cases.
module tb_io_handshake_port;

    logic       g_clk;
    logic       g_clr;
    logic [7:0] proc_data;
    logic       proc_req;
    logic       dev_ack;
    logic [7:0] dev_data;
    logic       dev_req;
    logic       proc_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] rx_count;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    logic       prev_req = 1'b0;
    int         max_cnt = 0;

    io_handshake_port #(.d_width(8), .depth(4)) dut (
        .g_clk     (g_clk),
        .g_clr     (g_clr),
        .proc_data (proc_data),
        .proc_req  (proc_req),
        .dev_ack   (dev_ack),
        .dev_data  (dev_data),
        .dev_req   (dev_req),
        .proc_ack  (proc_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Monitor: pops expected bytes whenever the DUT presents a transfer.
    always @(negedge g_clk) begin
        logic [7:0] e;
        if (rx_valid && rx_ready) begin
            if (rx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
            end else begin
                e = rx_exp.pop_front();
                check("rx_data_order", {24'd0, rx_data}, {24'd0, e});
            end
        end
        if (dev_req && !prev_req) begin
            if (tx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected actual=%0h required=none", dev_data);
            end else begin
                e = tx_exp.pop_front();
                check("tx_dev_data", {24'd0, dev_data}, {24'd0, e});
            end
        end
        prev_req = dev_req;
        if (int'(rx_count) > max_cnt) max_cnt = int'(rx_count);
    end

    task automatic rx_send(input logic [7:0] b);
        int n;
        proc_data = b;
        proc_req  = 1'b1;
        rx_exp.push_back(b);
        n = 0;
        do begin
            tick();
            n++;
        end while (!dev_ack && n < 40);
        check("rx_ack_rise", {31'd0, dev_ack}, 32'd1);
        proc_req = 1'b0;
        tick();
        check("rx_ack_fall", {31'd0, dev_ack}, 32'd0);
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        for (int i = 0; i < 20 && rx_count != 3'd0; i++) tick();
        rx_ready = 1'b0;
        check("drain_count", {29'd0, rx_count}, 32'd0);
    endtask

    initial begin
        g_clr     = 1'b1;
        proc_data = 8'h00;
        proc_req  = 1'b0;
        proc_ack  = 1'b0;
        rx_ready  = 1'b0;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;

        tick();
        check("rst_dev_ack",  {31'd0, dev_ack},  32'd0);
        check("rst_dev_req",  {31'd0, dev_req},  32'd0);
        check("rst_rx_count", {29'd0, rx_count}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_dev_data", {24'd0, dev_data}, 32'd0);
        tick();
        g_clr = 1'b0;
        tick();
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);

        // Single receive with exact handshake timing
        proc_data = 8'hA5;
        proc_req  = 1'b1;
        rx_exp.push_back(8'hA5);
        check("single_ack_pre", {31'd0, dev_ack}, 32'd0);
        tick();
        check("single_ack_rise", {31'd0, dev_ack},  32'd1);
        check("single_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("single_rx_data",  {24'd0, rx_data},  32'hA5);
        check("single_rx_count", {29'd0, rx_count}, 32'd1);
        proc_req = 1'b0;
        #1;
        check("single_ack_hold", {31'd0, dev_ack}, 32'd1);
        tick();
        check("single_ack_fall", {31'd0, dev_ack}, 32'd0);
        drain();

        // Full stall: four accepted, fifth waits for space
        for (int i = 1; i <= 4; i++) rx_send(8'(i));
        check("full_count", {29'd0, rx_count}, 32'd4);
        proc_data = 8'h05;
        proc_req  = 1'b1;
        rx_exp.push_back(8'h05);
        tick(); tick(); tick();
        check("stall_no_ack",  {31'd0, dev_ack},  32'd0);
        check("stall_count",   {29'd0, rx_count}, 32'd4);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("stall_pop_ack", {31'd0, dev_ack},  32'd0);
        check("stall_pop_cnt", {29'd0, rx_count}, 32'd3);
        tick();
        check("stall_ack_late", {31'd0, dev_ack},  32'd1);
        check("stall_refill",   {29'd0, rx_count}, 32'd4);
        proc_req = 1'b0;
        tick();
        check("stall_ack_fall", {31'd0, dev_ack}, 32'd0);
        drain();

        // Wrap with push and pop on the same cycle
        rx_send(8'h10);
        rx_send(8'h11);
        for (int i = 2; i < 10; i++) begin
            proc_data = 8'h10 + 8'(i);
            proc_req  = 1'b1;
            rx_ready  = 1'b1;
            rx_exp.push_back(8'h10 + 8'(i));
            tick();
            rx_ready = 1'b0;
            check("concurrent_count", {29'd0, rx_count}, 32'd2);
            check("concurrent_ack",   {31'd0, dev_ack},  32'd1);
            proc_req = 1'b0;
            tick();
            check("concurrent_ack_fall", {31'd0, dev_ack}, 32'd0);
        end
        drain();
        check("max_count_le_depth", {31'd0, (max_cnt <= 4)}, 32'd1);

        // Transmit handshake
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tx_exp.push_back(8'h3C);
        tick();
        tx_valid = 1'b0;
        check("tx_ready_busy", {31'd0, tx_ready}, 32'd0);
        check("tx_req_high",   {31'd0, dev_req},  32'd1);
        check("tx_data_req",   {24'd0, dev_data}, 32'h3C);
        tick(); tick();
        check("tx_req_wait", {31'd0, dev_req}, 32'd1);
        proc_ack = 1'b1;
        tick();
        check("tx_rel_req",   {31'd0, dev_req},  32'd0);
        check("tx_rel_ready", {31'd0, tx_ready}, 32'd0);
        check("tx_rel_data",  {24'd0, dev_data}, 32'h3C);
        proc_ack = 1'b0;
        tick();
        check("tx_done_ready", {31'd0, tx_ready}, 32'd1);

        // Reset mid-handshake on both paths
        proc_data = 8'h77;
        proc_req  = 1'b1;
        tx_data   = 8'h5A;
        tx_valid  = 1'b1;
        tx_exp.push_back(8'h5A);
        tick();
        tx_valid = 1'b0;
        tick();
        check("mid_ack_on", {31'd0, dev_ack}, 32'd1);
        check("mid_req_on", {31'd0, dev_req}, 32'd1);
        #1;
        g_clr = 1'b1;
        #1;
        check("mid_rst_ack",   {31'd0, dev_ack},  32'd0);
        check("mid_rst_req",   {31'd0, dev_req},  32'd0);
        check("mid_rst_count", {29'd0, rx_count}, 32'd0);
        check("mid_rst_data",  {24'd0, dev_data}, 32'd0);
        proc_req = 1'b0;
        rx_exp.delete();
        tick();
        g_clr = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, tx_ready}, 32'd1);
        rx_send(8'hA5);
        check("post_rst_count", {29'd0, rx_count}, 32'd1);
        drain();

        tick();
        check("rx_scoreboard_empty", rx_exp.size(), 32'd0);
        check("tx_scoreboard_empty", tx_exp.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
